uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
// - UART16550 transmit serializer; sits directly downstream of the TX FIFO (fifo_top).
// - Pops bytes from the FIFO and drives the serial TX line: start, 5-8 data bits LSB first,
//   optional parity, then 1/1.5/2 stop bits. Bit timing comes from the baud generator's 16x tick.
// - Reports shift-register-empty (tsre); the FIFO supplies THRE.
// PARAMETERS
// - OVERSAMPLE  16  baud_pulse ticks per bit; must be even (1.5 stop = 3*OVERSAMPLE/2)
// - DATA_W       8  FIFO data width; max word length
// PORTS
// - clk            in   1       system clock
// - rst            in   1       reset; synchronous, active-low
// - baud_pulse     in   1       1-cycle strobe at 16x baud rate
// - tx_en          in   1       1 = new frames may start; 0 = finish current frame, then idle
// - fifo_empty     in   1       TX FIFO empty
// - fifo_dout      in   DATA_W  FIFO head data; valid whenever fifo_empty=0 (show-ahead)
// - fifo_pop       out  1       1-cycle pop strobe to the FIFO
// - wls            in   2       word length: 00=5, 01=6, 10=7, 11=8 bits
// - stb            in   1       0 = 1 stop bit; 1 = 2 stop bits (1.5 when wls=00)
// - pen            in   1       parity enable
// - eps            in   1       1 = even, 0 = odd parity
// - sticky_par     in   1       sticky parity: parity bit = ~eps
// - set_break      in   1       force tx low
// - tx             out  1       serial line, idle high
// - tsre           out  1       1 = idle with no frame in progress
// BEHAVIOUR
// - Reset (rst=0 at posedge): state=IDLE, tx=1, fifo_pop=0, tsre=1, counters=0. Reset mid-frame
//   aborts the frame: tx=1 on the next cycle, no pop, partially sent byte is discarded.
// - FSM: IDLE -> START -> DATA -> [PARITY if pen] -> STOP -> IDLE | START.
//   The FSM advances only on cycles with baud_pulse=1.
// - IDLE: on baud_pulse & tx_en & !fifo_empty: fifo_pop=1 for exactly that cycle.
//   The same edge latches fifo_dout, wls, stb, pen, eps and sticky_par; the next state is START
//   with tick count 0. Config changes mid-frame therefore have no effect on the frame in progress.
// - Each START/DATA/PARITY bit lasts OVERSAMPLE baud_pulses.
//   STOP lasts OVERSAMPLE (stb=0), 3*OVERSAMPLE/2 (stb=1 and wls=00), or 2*OVERSAMPLE otherwise.
// - DATA: sends 5+wls bits, LSB first. Bits above the word length are ignored.
// - Parity bit value:
//   - sticky_par=1: ~eps
//   - otherwise: XOR of the sent data bits, XORed with ~eps (even parity makes the total count of 1s even)
// - Line levels: tx=0 in START; data or parity bit in DATA/PARITY; 1 in STOP and IDLE.
//   tx is registered, so a line change follows the state change by 1 clk.
// - Back-to-back frames: on the final STOP baud_pulse, if tx_en & !fifo_empty, pop and go directly
//   to START, leaving no idle bit time. Otherwise go to IDLE.
// - tsre=0 from the pop cycle+1 until the cycle after returning to IDLE; tsre=1 otherwise.
// - set_break: tx=0 while asserted, in any state. The FSM and timing run unaffected, so frames are
//   consumed and lost during break.
// - tx_en deasserted mid-frame: the current frame completes, then the FSM stays in IDLE.
// - fifo_pop is never asserted while fifo_empty=1, which rules out underrun by construction.
// - baud_pulse held high continuously is legal: one tick per clk.
// STRUCTURE
// - uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP); WLS_5..WLS_8 localparams;
//   helper function stop_ticks(stb, wls, OVERSAMPLE).
// - Sub-module uart_bit_timer: counts baud_pulse up to a loadable terminal count and emits a
//   1-cycle bit_done strobe. Also used later by the RX sampler.
// - Top level holds the FSM, shift register, bit counter, parity accumulator and latched config.
// TESTING (OVERSAMPLE=16, baud_pulse every 4 clk)
// - Reset: rst=0 for 5 clk with fifo non-empty -> tx=1, tsre=1, fifo_pop=0 throughout.
// - 8N1: byte 8'hA5 with wls=11, pen=0, stb=0 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 64 clk;
//   exactly one fifo_pop.
// - 7E2: byte 8'h53 with wls=10, pen=1, eps=1, stb=1 -> data 1,1,0,0,1,0,1, parity 0,
//   then 128 clk of stop; bit7 is ignored.
// - 5-bit 1.5 stop, sticky: 8'h1F with wls=00, pen=1, sticky_par=1, eps=0 -> parity bit 1,
//   stop lasts 96 clk.
// - Back-to-back: push 3 bytes, 8N1 -> 30 bit times of activity with no idle gap, 3 pops,
//   tsre=0 for the whole burst; fifo_empty=1 is never popped.
// - Abort/break: rst=0 mid-DATA -> tx=1 the next clk. Separately, set_break=1 mid-frame -> tx=0
//   while held; after release, frame timing is intact.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared types: TX FSM states, latched line config,
// word-length codes and stop-bit duration helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sticky;
  } tx_cfg_t;

  function automatic int unsigned stop_ticks(
    input logic        stb,
    input logic [1:0]  wls,
    input int unsigned os
  );
    if (!stb) return os;
    if (wls == WLS_5) return (3 * os) / 2;
    return 2 * os;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks up to a loadable terminal count
// and strobes done on the tick that completes the period.
module uart_bit_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = tick & ~clear &
                (cnt_q == term - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || done) cnt_d = '0;
    else if (tick)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops the TX FIFO and shifts
// start, data, parity and stop bits onto the line.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_pop,
  input  logic [1:0]        wls,
  input  logic              stb,
  input  logic              pen,
  input  logic              eps,
  input  logic              sticky_par,
  input  logic              set_break,
  output logic              tx,
  output logic              tsre
);

  localparam int unsigned CNT_W =
    $clog2(2 * OVERSAMPLE + 1);

  tx_state_t         state_q, state_d;
  tx_cfg_t           cfg_q, cfg_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              tsre_q, tsre_d;

  logic             bit_done;
  logic             start_frame;
  logic             last_bit;
  logic             par_bit;
  logic [CNT_W-1:0] term;

  assign term = (state_q == STOP) ?
    CNT_W'(stop_ticks(cfg_q.stb, cfg_q.wls, OVERSAMPLE)) :
    CNT_W'(OVERSAMPLE);

  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .tick  (baud_pulse),
    .term  (term),
    .done  (bit_done)
  );

  // A frame may start from IDLE or straight off the last stop tick
  assign start_frame = rst & baud_pulse & tx_en & ~fifo_empty &
    ((state_q == IDLE) | ((state_q == STOP) & bit_done));

  assign fifo_pop = start_frame;
  assign last_bit = bit_cnt_q == (3'd4 + {1'b0, cfg_q.wls});
  assign par_bit  = cfg_q.sticky ? ~cfg_q.eps :
                    par_q ^ ~cfg_q.eps;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    if (start_frame) begin
      state_d   = START;
      sh_d      = fifo_dout;
      bit_cnt_d = '0;
      par_d     = 1'b0;
      cfg_d     = '{wls: wls, stb: stb, pen: pen,
                    eps: eps, sticky: sticky_par};
    end else if (bit_done) begin
      unique case (state_q)
        IDLE:   state_d = IDLE;
        START:  state_d = DATA;
        DATA: begin
          sh_d      = sh_q >> 1;
          par_d     = par_q ^ sh_q[0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit)
            state_d = cfg_q.pen ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_d = 1'b1;
    if (set_break) tx_d = 1'b0;
    else begin
      unique case (state_q)
        START:   tx_d = 1'b0;
        DATA:    tx_d = sh_q[0];
        PARITY:  tx_d = par_bit;
        default: tx_d = 1'b1;
      endcase
    end
    tsre_d = (state_q == IDLE) & ~start_frame;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tsre_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tsre_q    <= tsre_d;
    end
  end

  assign tx   = tx_q;
  assign tsre = tsre_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: framing, parity,
// stop lengths, back-to-back, reset abort and break.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse = 1'b0;
  logic       tx_en;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_pop;
  logic [1:0] wls;
  logic       stb, pen, eps, sticky_par, set_break;
  logic       tx, tsre;

  logic [7:0] q[$];
  logic [1:0] bcnt = 2'd0;
  int pops = 0;
  int bad_pops = 0;
  int n_checks = 0;
  int n_fail = 0;

  uart_tx_engine #(.OVERSAMPLE(16), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .wls        (wls),
    .stb        (stb),
    .pen        (pen),
    .eps        (eps),
    .sticky_par (sticky_par),
    .set_break  (set_break),
    .tx         (tx),
    .tsre       (tsre)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bcnt       <= bcnt + 2'd1;
    baud_pulse <= (bcnt == 2'd3);
  end

  always @(posedge clk) begin
    if (fifo_pop) begin
      pops++;
      if (fifo_empty) bad_pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() == 0) ? 8'h00 : q[0];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    q.push_back(b);
  endtask

  task automatic cfg(input logic [1:0] w, input logic s,
                     input logic p, input logic e,
                     input logic st);
    wls = w; stb = s; pen = p; eps = e; sticky_par = st;
  endtask

  task automatic wait_fall(input string tag, output bit ok);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
    check({tag, "_fall"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_tsre(input int from, output int n);
    n = from;
    while (tsre !== 1'b1 && n < from + 4000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // bits[i] is the line level expected mid bit-time i
  task automatic run_frame(input string tag,
                           input logic [31:0] bits,
                           input int nbits, input int len);
    int n;
    bit ok;
    wait_fall(tag, ok);
    if (!ok) return;
    repeat (32) @(negedge clk);
    n = 32;
    check({tag, "_tsre"}, 32'(tsre), 32'd0);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        repeat (64) @(negedge clk);
        n += 64;
      end
      check($sformatf("%s_bit%0d", tag, i),
            32'(tx), 32'(bits[i]));
    end
    wait_tsre(n, n);
    check({tag, "_len"}, n, len);
  endtask

  function automatic logic [9:0] f8(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin
    int n;
    bit ok;
    rst = 1'b0; tx_en = 1'b1; set_break = 1'b0;
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset with a byte waiting
    push(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_tsre", 32'(tsre), 32'd1);
      check("rst_pop", 32'(fifo_pop), 32'd0);
    end
    rst = 1'b1;

    run_frame("8n1", 32'(f8(8'hA5)), 10, 640);
    check("8n1_pops", pops, 1);

    // 7E2, config scrambled after pop
    cfg(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    push(8'h53);
    n = 0;
    while (tsre !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("7e2_busy", 32'(tsre), 32'd0);
    cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("7e2", 32'b110_1010_0110, 11, 704);
    check("7e2_pops", pops, 2);

    // 5 bits, sticky parity, 1.5 stop
    cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    push(8'h1F);
    run_frame("5s15", 32'b1111_1110, 8, 544);
    check("5s15_pops", pops, 3);

    // back-to-back burst
    cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tx_en = 1'b0;
    push(8'h3C);
    push(8'h81);
    push(8'h00);
    repeat (20) @(negedge clk);
    check("b2b_hold", pops, 3);
    tx_en = 1'b1;
    run_frame("b2b",
      32'({f8(8'h00), f8(8'h81), f8(8'h3C)}), 30, 1920);
    check("b2b_pops", pops, 6);
    repeat (200) @(negedge clk);
    check("b2b_nopop", pops, 6);
    check("b2b_underrun", bad_pops, 0);

    // reset mid-DATA aborts
    push(8'h00);
    wait_fall("abort", ok);
    repeat (200) @(negedge clk);
    check("abort_pre", 32'(tx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_tsre", 32'(tsre), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_idle", 32'(tx), 32'd1);
    check("abort_pops", pops, 7);

    // break in the middle of an all-ones frame
    push(8'hFF);
    wait_fall("brk", ok);
    repeat (100) @(negedge clk);
    set_break = 1'b1;
    repeat (2) @(negedge clk);
    check("brk_low", 32'(tx), 32'd0);
    repeat (198) @(negedge clk);
    check("brk_held", 32'(tx), 32'd0);
    set_break = 1'b0;
    repeat (52) @(negedge clk);
    check("brk_bit5", 32'(tx), 32'd1);
    wait_tsre(352, n);
    check("brk_len", n, 640);
    check("brk_pops", pops, 8);
    check("underrun", bad_pops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule
